// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: 8N1 UART receiver feeding a DEPTH-entry byte FIFO with stall, overrun and frame-error flags.
// Optional macro UART_RX_MAJORITY_EN enables 2-of-3 voting on each data and stop bit.
module uart_rx_buffer #(
    parameter int CLK_PER_BIT = 868,
    parameter int DEPTH       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rxd,
    input  logic                     rd_req,
    output logic [7:0]               rd_data,
    output logic                     rd_valid,
    output logic                     uart_stall,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun,
    output logic                     frame_err,
    input  logic                     clr_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;
    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] HALF  = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULLB = CW'(CLK_PER_BIT - 1);
    localparam logic [AW:0]   FULL  = NW'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic rx_s1_q, rx_s2_q, rx_s3_q;
    logic line, prev, bit_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= rxd;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // The whole bit timeline shifts one cycle so s2/s3/s4 are mid+1/mid/mid-1.
    logic rx_s4_q;
    always_ff @(posedge clk) begin
        if (rst) rx_s4_q <= 1'b1;
        else     rx_s4_q <= rx_s3_q;
    end
    assign line    = rx_s3_q;
    assign prev    = rx_s4_q;
    assign bit_val = (rx_s2_q & rx_s3_q) | (rx_s2_q & rx_s4_q) | (rx_s3_q & rx_s4_q);
`else
    assign line    = rx_s2_q;
    assign prev    = rx_s3_q;
    assign bit_val = rx_s2_q;
`endif

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic          brk_q;
    logic          tick, push, ferr_set;

    assign tick     = cnt_q == '0;
    assign push     = state_q == STOP && !brk_q && tick && bit_val;
    assign ferr_set = state_q == STOP && !brk_q && tick && !bit_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            brk_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (prev && !line) begin
                    state_q <= START;
                    cnt_q   <= HALF;
                end
                START: if (!tick) cnt_q <= cnt_q - 1'b1;
                else if (line) state_q <= IDLE;
                else begin
                    state_q <= DATA;
                    cnt_q   <= FULLB;
                    idx_q   <= '0;
                end
                DATA: if (!tick) cnt_q <= cnt_q - 1'b1;
                else begin
                    shift_q <= {bit_val, shift_q[7:1]};
                    idx_q   <= idx_q + 3'd1;
                    cnt_q   <= FULLB;
                    if (idx_q == 3'd7) state_q <= STOP;
                end
                // A low stop bit parks here until the line returns high.
                STOP: if (brk_q) begin
                    if (line) begin
                        brk_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end else if (!tick) cnt_q <= cnt_q - 1'b1;
                else if (bit_val) state_q <= IDLE;
                else brk_q <= 1'b1;
                default: state_q <= IDLE;
            endcase
        end
    end

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    rd_data_q;
    logic          rd_valid_q, overrun_q, frame_err_q;
    logic          pop, full, wr;

    assign pop     = rd_req && count_q != '0;
    assign full    = count_q == FULL;
    assign wr      = push && (!full || pop);

    always_comb begin
        count_d = (wr && !pop) ? count_q + 1'b1 : (!wr && pop) ? count_q - 1'b1 : count_q;
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wptr_q] <= shift_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            rd_valid_q  <= pop;
            overrun_q   <= (push && full && !pop) || (overrun_q && !clr_err);
            frame_err_q <= ferr_set || (frame_err_q && !clr_err);
            if (wr) wptr_q <= wptr_q + 1'b1;
            if (pop) begin
                rd_data_q <= mem_q[rptr_q];
                rptr_q    <= rptr_q + 1'b1;
            end
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign count      = count_q;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;
    assign uart_stall = rd_req && count_q == '0;
endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb_uart_rx_buffer: directed plus randomized checks of uart_rx_buffer against a queue-based byte model.
module tb_uart_rx_buffer;
    localparam int CPB = 16;
    localparam int DEPTH = 4;

    logic       clk, rst, rxd, rd_req, clr_err;
    logic [7:0] rd_data;
    logic       rd_valid, uart_stall, overrun, frame_err;
    logic [2:0] count;

    uart_rx_buffer #(.CLK_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .rd_req(rd_req), .rd_data(rd_data),
        .rd_valid(rd_valid), .uart_stall(uart_stall), .count(count),
        .overrun(overrun), .frame_err(frame_err), .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         fails = 0;
    logic [7:0] q[$];
    logic       m_ovr = 1'b0;
    logic       m_ferr = 1'b0;
    logic [7:0] last_data = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            hold(CPB);
        end
        rxd = stop;
        hold(CPB);
        rxd = 1'b1;
        hold(6);
    endtask

    task automatic model_rx(input logic [7:0] b);
        if (q.size() < DEPTH) q.push_back(b);
        else m_ovr = 1'b1;
    endtask

    task automatic read_model(input string tag);
        logic [7:0] e;
        rd_req = 1'b1;
        #1;
        if (q.size() == 0) begin
            chk({tag, "_stall"}, uart_stall, 1);
            hold(1);
            rd_req = 1'b0;
            chk({tag, "_novalid"}, rd_valid, 0);
        end else begin
            e = q.pop_front();
            chk({tag, "_nostall"}, uart_stall, 0);
            hold(1);
            rd_req = 1'b0;
            chk({tag, "_valid"}, rd_valid, 1);
            chk({tag, "_data"}, rd_data, e);
            hold(1);
            chk({tag, "_pulse"}, rd_valid, 0);
            chk({tag, "_hold"}, rd_data, e);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_count"}, count, q.size());
        chk({tag, "_ovr"}, overrun, m_ovr);
        chk({tag, "_ferr"}, frame_err, m_ferr);
    endtask

    initial begin
        logic [7:0] b;
        logic       bad;
        rst = 1'b1; rxd = 1'b1; rd_req = 1'b0; clr_err = 1'b0;
        hold(3);
        rst = 1'b0;
        hold(1);
        chk("rst_count", count, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_stall", uart_stall, 0);

        send_byte(8'hA5, 1'b1);
        model_rx(8'hA5);
        chk("a5_count1", count, 1);
        read_model("a5");
        chk("a5_count0", count, 0);

        for (int i = 1; i <= 5; i++) begin
            b = 8'(i);
            send_byte(b, 1'b1);
            model_rx(b);
        end
        check_state("fill");
        chk("fill_ovr_set", overrun, 1);
        for (int i = 0; i < 4; i++) read_model("drain");
        read_model("drain5");
        clr_err = 1'b1;
        hold(1);
        clr_err = 1'b0;
        m_ovr = 1'b0;
        chk("ovr_clr", overrun, 0);

        rd_req = 1'b1;
        hold(1);
        chk("s35_stall", uart_stall, 1);
        fork
            send_byte(8'h3C, 1'b1);
            begin
                int n;
                n = 0;
                while (uart_stall && n < 400) begin
                    hold(1);
                    n++;
                end
                chk("s35_drop", uart_stall, 0);
                chk("s35_held", n > 20, 1);
                chk("s35_count1", count, 1);
                chk("s35_novalid", rd_valid, 0);
                hold(1);
                rd_req = 1'b0;
                chk("s35_valid", rd_valid, 1);
                chk("s35_data", rd_data, 8'h3C);
                chk("s35_count0", count, 0);
            end
        join

        send_byte(8'h55, 1'b0);
        m_ferr = 1'b1;
        check_state("ferr");
        clr_err = 1'b1;
        hold(1);
        clr_err = 1'b0;
        m_ferr = 1'b0;
        chk("ferr_clr", frame_err, 0);

        rxd = 1'b0;
        hold(4);
        rxd = 1'b1;
        hold(30);
        check_state("glitch");
        send_byte(8'h5A, 1'b1);
        model_rx(8'h5A);
        check_state("post_glitch");
        read_model("post_glitch");

        send_byte(8'h99, 1'b1);
        model_rx(8'h99);
        fork
            send_byte(8'hFF, 1'b1);
            begin
                hold(CPB + 3 * CPB + CPB / 2);
                rst = 1'b1;
                hold(2);
                rst = 1'b0;
            end
        join
        q.delete();
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        check_state("midrst");
        send_byte(8'h12, 1'b1);
        model_rx(8'h12);
        check_state("after_rst");
        read_model("after_rst");

        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom);
            bad = $urandom_range(0, 7) == 0;
            send_byte(b, !bad);
            if (bad) m_ferr = 1'b1;
            else model_rx(b);
            check_state("rnd");
            repeat ($urandom_range(0, 2)) read_model("rnd_rd");
            if ($urandom_range(0, 3) == 0) begin
                clr_err = 1'b1;
                hold(1);
                clr_err = 1'b0;
                m_ovr = 1'b0;
                m_ferr = 1'b0;
            end
        end
        check_state("final");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/uart_rx_buffer.md
UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200 baud).
REQ-002 SHALL have parameter DEPTH, default 16, meaning FIFO entries; power of two, 2..256.
REQ-003 SHALL have port clk  input  1  meaning the single core clock.
REQ-004 SHALL have port rst  input  1  meaning reset: synchronous, active-high.
REQ-005 SHALL have port rxd  input  1  meaning asynchronous serial line, 8N1, idle high.
REQ-006 SHALL have port rd_req  input  1  meaning core requests one received byte.
REQ-007 SHALL have port rd_data  output  8  meaning popped byte.
REQ-008 SHALL have port rd_valid  output  1  meaning rd_data valid this cycle.
REQ-009 SHALL have port uart_stall  output  1  meaning core must hold its pipeline.
REQ-010 SHALL have port count  output  $clog2(DEPTH)+1  meaning FIFO occupancy.
REQ-011 SHALL have port overrun  output  1  meaning sticky: a byte was dropped because the FIFO was full.
REQ-012 SHALL have port frame_err  output  1  meaning sticky: a bad stop bit was seen.
REQ-013 SHALL have port clr_err  input  1  meaning clears overrun and frame_err.

Function
REQ-014 SHALL pass rxd through a 2-FF synchronizer; all receiver logic SHALL use the synchronized value.
REQ-015 Receiver FSM SHALL have states IDLE, START, DATA, STOP and SHALL use a single baud counter.
REQ-016 IDLE->START SHALL occur on a synchronized falling edge; the baud counter SHALL load CLK_PER_BIT/2-1.
REQ-017 START: at counter 0, line low SHALL go to DATA with counter CLK_PER_BIT-1; line high SHALL return to IDLE as a glitch, with no push and no error.
REQ-018 DATA SHALL sample 8 bits, LSB first, one per CLK_PER_BIT at mid-bit, then go to STOP.
REQ-019 STOP: at mid-bit, line high SHALL push the byte and return to IDLE; line low SHALL set frame_err, discard the byte, and return to IDLE only after the line is seen high.
REQ-020 Push SHALL occur exactly once per valid frame, in the cycle the stop bit is sampled.
REQ-021 Push when full without a same-cycle pop SHALL drop the byte, set overrun, and leave FIFO contents unchanged.
REQ-022 Pop SHALL occur when rd_req=1 and count!=0; rd_data SHALL be the oldest byte, registered, with rd_valid=1 for exactly the next cycle.
REQ-023 uart_stall SHALL equal rd_req && (count==0), combinationally from registered count.
REQ-024 Push and pop in the same cycle SHALL both take effect; count SHALL be unchanged (full stays full, no overrun).
REQ-025 Push and rd_req in the same cycle with count==0 SHALL stall that cycle and pop the byte on the next cycle.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH.
REQ-027 clr_err SHALL clear both sticky flags next cycle; a same-cycle set SHALL win over clr_err.
REQ-028 rd_data SHALL hold its last value when rd_valid=0.

Reset
REQ-029 rst SHALL force IDLE, counter 0, pointers 0, count 0, rd_valid 0, rd_data 0, overrun 0, frame_err 0, and synchronizer flops 1.
REQ-030 rst mid-frame SHALL abandon the frame with no push; reception SHALL resume on the next falling edge after rst deasserts.

Configuration
REQ-031 Macro UART_RX_MAJORITY_EN defined SHALL take each data/stop bit as the 2-of-3 vote of samples at mid-bit-1, mid-bit, mid-bit+1; the START check SHALL remain a single sample.
REQ-032 Without UART_RX_MAJORITY_EN, each bit SHALL be a single mid-bit sample, with no extra logic.

Verification (CLK_PER_BIT=16, DEPTH=4)
REQ-033 Send 0xA5, then rd_req pulse -> rd_valid one cycle later with rd_data=0xA5; count 1->0.
REQ-034 Send 5 bytes 0x01..0x05 with no reads -> count=4, overrun=1; reads return 0x01..0x04; a 5th read stalls.
REQ-035 rd_req held with FIFO empty, then 0x3C arrives -> uart_stall=1 until the push, rd_data=0x3C one cycle after the stall drops.
REQ-036 Frame 0x55 with stop bit low -> frame_err=1, count unchanged; clr_err -> frame_err=0.
REQ-037 Low glitch of 4 cycles on idle line -> no push, no error, FSM back in IDLE.
REQ-038 Assert rst during bit 3 of 0xFF, then send 0x12 -> only 0x12 is received; count=1.
